seven_segment_scanner: RTL and testbench

SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

---
 rtl/seven_segment_pkg.sv | 32 +++
 rtl/bcd_to_segments.sv | 26 ++
 rtl/seven_segment_scanner.sv | 162 ++++++++++++++++
 tb/tb_seven_segment_scanner.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_pkg.sv
// Shared encodings for the seven-segment scanner: FSM states, segment bit
// positions and the active-high glyph patterns ({g,f,e,d,c,b,a}).
package seven_segment_pkg;

  typedef enum logic {
    SHOW  = 1'b0,
    GUARD = 1'b1
  } scan_state_e;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_DASH  = 7'h40;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_segments.sv
// Combinational BCD to active-high segment decode; non-BCD codes show a dash.
module bcd_to_segments
  import seven_segment_pkg::*;
(
  input  logic [3:0] value_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = GLYPH_DASH;
    case (value_i)
      4'd0:    seg_o = GLYPH_0;
      4'd1:    seg_o = GLYPH_1;
      4'd2:    seg_o = GLYPH_2;
      4'd3:    seg_o = GLYPH_3;
      4'd4:    seg_o = GLYPH_4;
      4'd5:    seg_o = GLYPH_5;
      4'd6:    seg_o = GLYPH_6;
      4'd7:    seg_o = GLYPH_7;
      4'd8:    seg_o = GLYPH_8;
      4'd9:    seg_o = GLYPH_9;
      default: seg_o = GLYPH_DASH;
    endcase
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Four-digit multiplexed seven-segment scanner with guard gaps between digits
// and frame-synchronous double-buffered data loading.
module seven_segment_scanner
  import seven_segment_pkg::*;
#(
  parameter bit          ENABLE_ACTIVE_LOW  = 1'b1,
  parameter bit          SEGMENT_ACTIVE_LOW = 1'b1,
  parameter int unsigned GUARD_CYCLES       = 2
) (
  input  logic        cmosClock,
  input  logic        reset,
  input  logic        scanTick,
  input  logic [15:0] digitsIn,
  input  logic [3:0]  dpIn,
  input  logic        loadStrobe,
  input  logic        blankLeading,
  output logic        loadAck,
  output logic        frameStart,
  output logic [3:0]  sevenSegmentEnable,
  output logic [7:0]  sevenSegmentData
);

  localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES);
  localparam logic [3:0] EN_OFF     = ENABLE_ACTIVE_LOW  ? 4'hF  : 4'h0;
  localparam logic [7:0] SEG_OFF    = SEGMENT_ACTIVE_LOW ? 8'hFF : 8'h00;

  scan_state_e      state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       guard_q, guard_d;
  logic [3:0][3:0]  act_dig_q, act_dig_d;
  logic [3:0]       act_dp_q, act_dp_d;
  logic [3:0][3:0]  pend_dig_q, pend_dig_d;
  logic [3:0]       pend_dp_q, pend_dp_d;
  logic             pend_vld_q, pend_vld_d;
  logic             ack_q, ack_d;
  logic             frame_q, frame_d;
  logic [3:0]       en_q, en_d;
  logic [7:0]       data_q, data_d;

  logic             wrap;
  logic [3:0]       cur_val;
  logic [6:0]       dec_seg;
  logic [6:0]       seg_raw;
  logic [3:0]       en_raw;
  logic [7:0]       data_raw;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    guard_d    = guard_q;
    act_dig_d  = act_dig_q;
    act_dp_d   = act_dp_q;
    pend_dig_d = pend_dig_q;
    pend_dp_d  = pend_dp_q;
    pend_vld_d = pend_vld_q;
    ack_d      = 1'b0;
    wrap       = 1'b0;

    case (state_q)
      SHOW: begin
        if (scanTick) begin
          idx_d = idx_q - 2'd1;
          wrap  = (idx_q == 2'd0);
          if (GUARD_LOAD != 8'd0) begin
            state_d = GUARD;
            guard_d = GUARD_LOAD;
          end
        end
      end
      GUARD: begin
        // Leave on the cycle the count would reach zero: GUARD_LOAD off cycles.
        if (guard_q <= 8'd1) begin
          state_d = SHOW;
          guard_d = 8'd0;
        end else begin
          guard_d = guard_q - 8'd1;
        end
      end
      default: state_d = SHOW;
    endcase

    // A strobe on the wrap cycle bypasses the pending buffer.
    if (wrap) begin
      if (loadStrobe) begin
        act_dig_d  = digitsIn;
        act_dp_d   = dpIn;
        ack_d      = 1'b1;
        pend_vld_d = 1'b0;
      end else if (pend_vld_q) begin
        act_dig_d  = pend_dig_q;
        act_dp_d   = pend_dp_q;
        ack_d      = 1'b1;
        pend_vld_d = 1'b0;
      end
    end else if (loadStrobe) begin
      pend_dig_d = digitsIn;
      pend_dp_d  = dpIn;
      pend_vld_d = 1'b1;
    end

    frame_d = wrap;
    cur_val = act_dig_d[idx_d];
  end

  bcd_to_segments u_dec (
    .value_i (cur_val),
    .seg_o   (dec_seg)
  );

  // Output register is loaded from next state so a new digit is visible on
  // its first SHOW cycle.
  always_comb begin
    seg_raw  = dec_seg;
    en_raw   = 4'h0;
    data_raw = 8'h00;
    if (blankLeading && (idx_d == 2'd3) && (cur_val == 4'd0))
      seg_raw = GLYPH_BLANK;
    if (state_d == SHOW) begin
      en_raw                 = 4'b0001 << idx_d;
      data_raw[SEG_G:SEG_A]  = seg_raw;
      data_raw[SEG_DP]       = act_dp_d[idx_d];
    end
    en_d   = ENABLE_ACTIVE_LOW  ? ~en_raw   : en_raw;
    data_d = SEGMENT_ACTIVE_LOW ? ~data_raw : data_raw;
  end

  always_ff @(posedge cmosClock) begin
    if (reset) begin
      state_q    <= SHOW;
      idx_q      <= 2'd3;
      guard_q    <= 8'd0;
      act_dig_q  <= '0;
      act_dp_q   <= '0;
      pend_dig_q <= '0;
      pend_dp_q  <= '0;
      pend_vld_q <= 1'b0;
      ack_q      <= 1'b0;
      frame_q    <= 1'b0;
      en_q       <= EN_OFF;
      data_q     <= SEG_OFF;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      guard_q    <= guard_d;
      act_dig_q  <= act_dig_d;
      act_dp_q   <= act_dp_d;
      pend_dig_q <= pend_dig_d;
      pend_dp_q  <= pend_dp_d;
      pend_vld_q <= pend_vld_d;
      ack_q      <= ack_d;
      frame_q    <= frame_d;
      en_q       <= en_d;
      data_q     <= data_d;
    end
  end

  assign loadAck            = ack_q;
  assign frameStart         = frame_q;
  assign sevenSegmentEnable = en_q;
  assign sevenSegmentData   = data_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner: default build plus a GUARD_CYCLES=0 build.
module tb_seven_segment_scanner;

  logic        clk = 1'b0;
  logic        reset, scanTick, loadStrobe, blankLeading;
  logic [15:0] digitsIn;
  logic [3:0]  dpIn;
  logic        loadAck, frameStart, loadAck0, frameStart0;
  logic [3:0]  en, en0;
  logic [7:0]  seg, seg0;
  int          total = 0;
  int          bad = 0;
  int          ack_seen = 0;

  always #5 clk = ~clk;

  seven_segment_scanner u_dut (
    .cmosClock          (clk),
    .reset              (reset),
    .scanTick           (scanTick),
    .digitsIn           (digitsIn),
    .dpIn               (dpIn),
    .loadStrobe         (loadStrobe),
    .blankLeading       (blankLeading),
    .loadAck            (loadAck),
    .frameStart         (frameStart),
    .sevenSegmentEnable (en),
    .sevenSegmentData   (seg)
  );

  seven_segment_scanner #(.GUARD_CYCLES(0)) u_dut0 (
    .cmosClock          (clk),
    .reset              (reset),
    .scanTick           (scanTick),
    .digitsIn           (digitsIn),
    .dpIn               (dpIn),
    .loadStrobe         (loadStrobe),
    .blankLeading       (blankLeading),
    .loadAck            (loadAck0),
    .frameStart         (frameStart0),
    .sevenSegmentEnable (en0),
    .sevenSegmentData   (seg0)
  );

  task automatic step();
    @(posedge clk);
    #1;
    if (loadAck) ack_seen++;
  endtask

  // One tick from SHOW, then ride out the two guard cycles.
  task automatic advance();
    scanTick = 1'b1;
    step();
    scanTick = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; scanTick = 1'b0; loadStrobe = 1'b0; blankLeading = 1'b0;
    digitsIn = 16'h0; dpIn = 4'h0;
    step(); step(); step();
    total++; if (en !== 4'hF || seg !== 8'hFF) begin bad++;
      $display("FAIL reset_outputs en=%h seg=%h want F/FF", en, seg); end
    total++; if (loadAck !== 1'b0 || frameStart !== 1'b0) begin bad++;
      $display("FAIL reset_pulses ack=%b fs=%b want 0/0", loadAck, frameStart); end
    reset = 1'b0;
    step();
    total++; if (en !== 4'b0111 || seg !== 8'hC0) begin bad++;
      $display("FAIL reset_release en=%b seg=%h want 0111/C0", en, seg); end
    blankLeading = 1'b1; reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    total++; if (en !== 4'b0111 || seg !== 8'hFF) begin bad++;
      $display("FAIL reset_blank en=%b seg=%h want 0111/FF", en, seg); end
    blankLeading = 1'b0;
    step();
  endtask

  task automatic test_load();
    advance();
    total++; if (en !== 4'b1011 || seg !== 8'hC0) begin bad++;
      $display("FAIL load_pre en=%b seg=%h want 1011/C0", en, seg); end
    digitsIn = 16'h1234; dpIn = 4'b0100; loadStrobe = 1'b1;
    step();
    loadStrobe = 1'b0; digitsIn = 16'h0; dpIn = 4'h0;
    total++; if (loadAck !== 1'b0 || seg !== 8'hC0) begin bad++;
      $display("FAIL load_midframe ack=%b seg=%h want 0/C0", loadAck, seg); end
    advance(); advance();
    total++; if (en !== 4'b1110 || seg !== 8'hC0) begin bad++;
      $display("FAIL load_notear en=%b seg=%h want 1110/C0", en, seg); end
    scanTick = 1'b1;
    step();
    scanTick = 1'b0;
    total++; if (loadAck !== 1'b1 || frameStart !== 1'b1) begin bad++;
      $display("FAIL load_wrap ack=%b fs=%b want 1/1", loadAck, frameStart); end
    total++; if (en !== 4'hF || seg !== 8'hFF) begin bad++;
      $display("FAIL load_wrap_off en=%h seg=%h want F/FF", en, seg); end
    step();
    total++; if (loadAck !== 1'b0 || frameStart !== 1'b0) begin bad++;
      $display("FAIL load_pulse_width ack=%b fs=%b want 0/0", loadAck, frameStart); end
    step();
    total++; if (en !== 4'b0111 || seg !== 8'hF9) begin bad++;
      $display("FAIL load_d3 en=%b seg=%h want 0111/F9", en, seg); end
    advance();
    total++; if (en !== 4'b1011 || seg !== 8'h24) begin bad++;
      $display("FAIL load_d2 en=%b seg=%h want 1011/24", en, seg); end
    advance();
    total++; if (en !== 4'b1101 || seg !== 8'hB0) begin bad++;
      $display("FAIL load_d1 en=%b seg=%h want 1101/B0", en, seg); end
    advance();
    total++; if (en !== 4'b1110 || seg !== 8'h99) begin bad++;
      $display("FAIL load_d0 en=%b seg=%h want 1110/99", en, seg); end
  endtask

  task automatic test_guard();
    logic [3:0] exp_en [4];
    logic [7:0] exp_seg [4];
    exp_en  = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    exp_seg = '{8'hF9, 8'h24, 8'hB0, 8'h99};
    ack_seen = 0;
    for (int i = 0; i < 4; i++) begin
      scanTick = 1'b1;
      step();
      scanTick = 1'b0;
      total++; if (en !== 4'hF || seg !== 8'hFF) begin bad++;
        $display("FAIL guard_off1[%0d] en=%h seg=%h want F/FF", i, en, seg); end
      step();
      total++; if (en !== 4'hF || seg !== 8'hFF) begin bad++;
        $display("FAIL guard_off2[%0d] en=%h seg=%h want F/FF", i, en, seg); end
      step();
      total++; if (en !== exp_en[i] || seg !== exp_seg[i]) begin bad++;
        $display("FAIL guard_show[%0d] en=%b seg=%h want %b/%h", i, en, seg, exp_en[i], exp_seg[i]); end
      repeat (7) step();
    end
    total++; if (ack_seen !== 0) begin bad++;
      $display("FAIL guard_no_ack acks=%0d want 0", ack_seen); end
    scanTick = 1'b1;
    step();
    step();
    scanTick = 1'b0;
    step();
    total++; if (en !== 4'b0111 || seg !== 8'hF9) begin bad++;
      $display("FAIL guard_ignore en=%b seg=%h want 0111/F9", en, seg); end
    repeat (3) step();
    total++; if (en !== 4'b0111) begin bad++;
      $display("FAIL guard_hold en=%b want 0111", en); end
  endtask

  task automatic test_latest_wins();
    ack_seen = 0;
    digitsIn = 16'h1111; dpIn = 4'h0; loadStrobe = 1'b1;
    step();
    loadStrobe = 1'b0;
    advance();
    digitsIn = 16'h5678; loadStrobe = 1'b1;
    step();
    loadStrobe = 1'b0;
    total++; if (en !== 4'b1011 || seg !== 8'h24) begin bad++;
      $display("FAIL latest_notear en=%b seg=%h want 1011/24", en, seg); end
    advance(); advance();
    scanTick = 1'b1;
    step();
    scanTick = 1'b0;
    total++; if (loadAck !== 1'b1 || frameStart !== 1'b1) begin bad++;
      $display("FAIL latest_wrap ack=%b fs=%b want 1/1", loadAck, frameStart); end
    step(); step();
    total++; if (en !== 4'b0111 || seg !== 8'h92) begin bad++;
      $display("FAIL latest_d3 en=%b seg=%h want 0111/92", en, seg); end
    advance();
    total++; if (en !== 4'b1011 || seg !== 8'h82) begin bad++;
      $display("FAIL latest_d2 en=%b seg=%h want 1011/82", en, seg); end
    advance();
    total++; if (en !== 4'b1101 || seg !== 8'hF8) begin bad++;
      $display("FAIL latest_d1 en=%b seg=%h want 1101/F8", en, seg); end
    advance();
    total++; if (en !== 4'b1110 || seg !== 8'h80) begin bad++;
      $display("FAIL latest_d0 en=%b seg=%h want 1110/80", en, seg); end
    total++; if (ack_seen !== 1) begin bad++;
      $display("FAIL latest_ack_count acks=%0d want 1", ack_seen); end
  endtask

  task automatic test_dash_and_wrap_commit();
    logic [3:0] exp_en [3];
    logic [7:0] exp_seg [3];
    exp_en  = '{4'b1011, 4'b1101, 4'b1110};
    exp_seg = '{8'hC0, 8'hBF, 8'h90};
    digitsIn = 16'hA0B9; dpIn = 4'h0; loadStrobe = 1'b1; scanTick = 1'b1;
    step();
    loadStrobe = 1'b0; scanTick = 1'b0;
    total++; if (loadAck !== 1'b1 || frameStart !== 1'b1) begin bad++;
      $display("FAIL direct_commit ack=%b fs=%b want 1/1", loadAck, frameStart); end
    step(); step();
    total++; if (en !== 4'b0111 || seg !== 8'hBF) begin bad++;
      $display("FAIL dash_d3 en=%b seg=%h want 0111/BF", en, seg); end
    for (int i = 0; i < 3; i++) begin
      advance();
      total++; if (en !== exp_en[i] || seg !== exp_seg[i]) begin bad++;
        $display("FAIL dash_seq[%0d] en=%b seg=%h want %b/%h", i, en, seg, exp_en[i], exp_seg[i]); end
    end
    // Leading zero blanked, but its decimal point stays lit.
    digitsIn = 16'h0123; dpIn = 4'b1000; loadStrobe = 1'b1; scanTick = 1'b1; blankLeading = 1'b1;
    step();
    loadStrobe = 1'b0; scanTick = 1'b0;
    step(); step();
    total++; if (en !== 4'b0111 || seg !== 8'h7F) begin bad++;
      $display("FAIL blank_dp en=%b seg=%h want 0111/7F", en, seg); end
    blankLeading = 1'b0;
    step();
    total++; if (seg !== 8'h40) begin bad++;
      $display("FAIL unblank seg=%h want 40", seg); end
  endtask

  task automatic test_reset_guard();
    digitsIn = 16'h9999; dpIn = 4'hF; loadStrobe = 1'b1;
    step();
    loadStrobe = 1'b0;
    scanTick = 1'b1;
    step();
    scanTick = 1'b0;
    reset = 1'b1;
    step();
    total++; if (en !== 4'hF || seg !== 8'hFF || loadAck !== 1'b0) begin bad++;
      $display("FAIL rstguard_off en=%h seg=%h ack=%b want F/FF/0", en, seg, loadAck); end
    reset = 1'b0;
    step();
    total++; if (en !== 4'b0111 || seg !== 8'hC0) begin bad++;
      $display("FAIL rstguard_restart en=%b seg=%h want 0111/C0", en, seg); end
    ack_seen = 0;
    advance(); advance(); advance();
    scanTick = 1'b1;
    step();
    scanTick = 1'b0;
    total++; if (frameStart !== 1'b1 || loadAck !== 1'b0) begin bad++;
      $display("FAIL rstguard_wrap fs=%b ack=%b want 1/0", frameStart, loadAck); end
    step(); step();
    total++; if (en !== 4'b0111 || seg !== 8'hC0) begin bad++;
      $display("FAIL rstguard_discard en=%b seg=%h want 0111/C0", en, seg); end
    total++; if (ack_seen !== 0) begin bad++;
      $display("FAIL rstguard_acks acks=%0d want 0", ack_seen); end
  endtask

  task automatic test_guard0();
    logic [3:0] exp_en [4];
    exp_en = '{4'b1011, 4'b1101, 4'b1110, 4'b0111};
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    total++; if (en0 !== 4'b0111 || seg0 !== 8'hC0) begin bad++;
      $display("FAIL g0_start en=%b seg=%h want 0111/C0", en0, seg0); end
    scanTick = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (en0 !== exp_en[i] || seg0 !== 8'hC0) begin bad++;
        $display("FAIL g0_seq[%0d] en=%b seg=%h want %b/C0", i, en0, seg0, exp_en[i]); end
    end
    total++; if (frameStart0 !== 1'b1) begin bad++;
      $display("FAIL g0_wrap fs=%b want 1", frameStart0); end
    scanTick = 1'b0;
    step();
    total++; if (frameStart0 !== 1'b0 || en0 !== 4'b0111) begin bad++;
      $display("FAIL g0_hold fs=%b en=%b want 0/0111", frameStart0, en0); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_guard();
    test_latest_wins();
    test_dash_and_wrap_commit();
    test_reset_guard();
    test_guard0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
